// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads imem over req/ack, holds the word for decode; 2 cycles/instr minimum.
// Backpressure: instr is held while instr_valid && !instr_ready; a silent imem raises sticky fetch_err.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instr,
  output logic [5:0]            opcode,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  branch,
  input  logic                  zero,
  input  logic                  jump,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  output logic                  fetch_err
);

  localparam logic [ADDR_WIDTH-1:0] PC_INIT  = {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
  localparam int                    CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, VALID, ERR} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   pc_q, next_pc, jump_tgt, br_off;
  logic [31:0]             instr_q;
  logic [CNT_W-1:0]        cnt;
  logic                    timeout_hit;
  logic                    accept;

  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt == CNT_LAST);
  assign accept      = (state == VALID) && instr_ready;
  assign pc_plus4    = pc_q + ADDR_WIDTH'(4);
  assign br_off      = {{(ADDR_WIDTH-18){instr_q[15]}}, instr_q[15:0], 2'b00};

  // Jump keeps the top nibble of pc_plus4 only when the address is wider than the 28-bit target.
  if (ADDR_WIDTH > 28) begin : g_jmp_hi
    assign jump_tgt = {pc_plus4[ADDR_WIDTH-1:28], instr_q[25:0], 2'b00};
  end else begin : g_jmp_lo
    assign jump_tgt = {instr_q[25:0], 2'b00};
  end

  always_comb begin
    next_pc = pc_plus4;
    if (jump)
      next_pc = jump_tgt;
    else if (branch && zero)
      next_pc = pc_plus4 + br_off;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ: begin
        if (imem_ack)
          state_nxt = VALID;
        else if (timeout_hit)
          state_nxt = ERR;
      end
      VALID:   if (instr_ready) state_nxt = REQ;
      ERR:     state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  // cnt is held at zero outside REQ, so every entry to REQ starts a fresh wait window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= PC_INIT;
      instr_q <= '0;
      cnt     <= '0;
    end else begin
      if (state == REQ && imem_ack)
        instr_q <= imem_rdata;
      if (accept)
        pc_q <= next_pc;
      if (state != REQ)
        cnt <= '0;
      else if (!imem_ack && (MEM_TIMEOUT != 0) && !timeout_hit)
        cnt <= cnt + CNT_W'(1);
    end
  end

  assign imem_req    = (state == REQ);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_valid = (state == VALID);
  assign fetch_err   = (state == ERR);

endmodule
